adc_frontend: RTL and testbench



---
 rtl/adc_frontend.sv | 204 ++++++++++++++++++++
 tb/tb_adc_frontend.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frontend.sv
// adc_frontend: ADC input conditioning ahead of the wideband receiver.
//
// Registers the raw ADC sample and overrange pin, optionally inverts the sign
// and removes DC with a leaky integrator, saturates, and drives the receiver.
// Exports a DC estimate and a peak-hold magnitude for host telemetry.
//
// Fixed 2-cycle latency from adc_in/adc_ovr_in to adc_data/adc_ovfl.
//   S1: optional saturating negation of adc_in.
//   S2: optional DC subtraction and saturation.
//
// Build option: define ADC_FE_PEAK_EN to include the peak detector. Without
// it, peak_A is tied to 0 and peak_clr_A is ignored.
//
// Ports:
//   adc_clk       in   sample clock, the only clock
//   rst           in   synchronous active-high reset
//   adc_in        in   raw signed ADC sample
//   adc_ovr_in    in   ADC overrange pin
//   cfg_strobe_A  in   one-cycle config load pulse
//   cfg_A         in   config word: [0] dc_en, [1] invert, [2] dc_clr (pulse),
//                      [7:4] DC shift k (clamped to >= 4)
//   peak_clr_A    in   one-cycle peak detector clear
//   adc_data      out  conditioned signed sample
//   adc_ovfl      out  per-sample overflow flag
//   dc_est_A      out  current DC estimate, signed
//   peak_A        out  peak-hold magnitude
module adc_frontend #(
  parameter int ADC_BITS       = 14,
  parameter int DC_ACC_GUARD   = 16,
  parameter int PEAK_HOLD_BITS = 20
) (
  input  logic                adc_clk,
  input  logic                rst,
  input  logic [ADC_BITS-1:0] adc_in,
  input  logic                adc_ovr_in,
  input  logic                cfg_strobe_A,
  input  logic [31:0]         cfg_A,
  input  logic                peak_clr_A,
  output logic [ADC_BITS-1:0] adc_data,
  output logic                adc_ovfl,
  output logic [ADC_BITS-1:0] dc_est_A,
  output logic [ADC_BITS-2:0] peak_A
);

  localparam int N  = ADC_BITS;
  localparam int AW = ADC_BITS + DC_ACC_GUARD;
  localparam logic [N-1:0] POS_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] NEG_MIN = {1'b1, {(N-1){1'b0}}};

  // ---------------------------------------------------------------- config
  logic       r_dc_en;
  logic       r_invert;
  logic [3:0] r_k;
  logic [3:0] w_cfg_k;
  logic       w_dc_clr;
  logic       w_dc_off;

  assign w_cfg_k  = (cfg_A[7:4] < 4'd4) ? 4'd4 : cfg_A[7:4];
  assign w_dc_clr = cfg_strobe_A & cfg_A[2];
  // Turning the DC loop off also discards its state.
  assign w_dc_off = cfg_strobe_A & r_dc_en & ~cfg_A[0];

  always_ff @(posedge adc_clk) begin
    if (rst) begin
      r_dc_en  <= 1'b0;
      r_invert <= 1'b0;
      r_k      <= 4'd12;
    end else if (cfg_strobe_A) begin
      r_dc_en  <= cfg_A[0];
      r_invert <= cfg_A[1];
      r_k      <= w_cfg_k;
    end
  end

  // ------------------------------------------------------- S1: inversion
  logic         w_in_min;
  logic         w_neg_sat;
  logic [N-1:0] w_x1_d;
  logic [N-1:0] r_x1;
  logic         r_o1;

  assign w_in_min  = (adc_in == NEG_MIN);
  assign w_neg_sat = r_invert & w_in_min;

  always_comb begin
    w_x1_d = adc_in;
    if (r_invert) begin
      w_x1_d = w_in_min ? POS_MAX : -adc_in;
    end
  end

  always_ff @(posedge adc_clk) begin
    if (rst) begin
      r_x1 <= '0;
      r_o1 <= 1'b0;
    end else begin
      r_x1 <= w_x1_d;
      r_o1 <= adc_ovr_in | w_neg_sat;
    end
  end

  // ------------------------------------------------------- DC accumulator
  logic signed [AW-1:0] r_acc;
  logic signed [AW-1:0] w_acc_shr;
  logic signed [AW-1:0] w_acc_nxt;
  logic        [N-1:0]  w_dc_est;

  // k is applied directly to the live accumulator; a k change is not
  // compensated, so a short transient in dc_est is expected.
  assign w_acc_shr = r_acc >>> r_k;
  assign w_acc_nxt = r_acc + $signed({{DC_ACC_GUARD{r_x1[N-1]}}, r_x1}) - w_acc_shr;
  assign w_dc_est  = w_acc_shr[N-1:0];

  always_ff @(posedge adc_clk) begin
    if (rst || w_dc_clr || w_dc_off) begin
      r_acc <= '0;
    end else if (r_dc_en) begin
      r_acc <= w_acc_nxt;
    end
  end

  // ---------------------------------------------- S2: DC removal + clamp
  logic [N:0]   w_y;
  logic         w_y_ovf;
  logic         w_sat2;
  logic [N-1:0] w_data_d;
  logic [N-1:0] r_data;
  logic         r_ovfl;

  assign w_y     = {r_x1[N-1], r_x1} - {w_dc_est[N-1], w_dc_est};
  assign w_y_ovf = w_y[N] ^ w_y[N-1];

  always_comb begin
    w_data_d = r_x1;
    w_sat2   = 1'b0;
    if (r_dc_en) begin
      w_sat2 = w_y_ovf;
      if (w_y_ovf) begin
        w_data_d = w_y[N] ? NEG_MIN : POS_MAX;
      end else begin
        w_data_d = w_y[N-1:0];
      end
    end
  end

  always_ff @(posedge adc_clk) begin
    if (rst) begin
      r_data <= '0;
      r_ovfl <= 1'b0;
    end else begin
      r_data <= w_data_d;
      r_ovfl <= r_o1 | w_sat2;
    end
  end

  assign adc_data = r_data;
  assign adc_ovfl = r_ovfl;
  assign dc_est_A = w_dc_est;

  // --------------------------------------------------------- peak detector
`ifdef ADC_FE_PEAK_EN
  logic [N-1:0]              w_abs;
  logic [N-2:0]              w_mag;
  logic [N-2:0]              w_peak_shr;
  logic [N-2:0]              w_dec;
  logic [N-2:0]              w_peak_dec;
  logic [N-2:0]              r_peak;
  logic [PEAK_HOLD_BITS-1:0] r_hold;

  // Full-scale negative has no positive twin; it reads as the max magnitude.
  assign w_abs      = r_data[N-1] ? -r_data : r_data;
  assign w_mag      = (r_data == NEG_MIN) ? {(N-1){1'b1}} : w_abs[N-2:0];
  assign w_peak_shr = r_peak >> 4;
  // Decay by 1/16 per hold period, but at least 1 LSB so it reaches 0.
  assign w_dec      = (w_peak_shr == '0) ? (N-1)'(1) : w_peak_shr;
  assign w_peak_dec = (r_peak >= w_dec) ? (r_peak - w_dec) : '0;

  always_ff @(posedge adc_clk) begin
    if (rst || peak_clr_A) begin
      r_peak <= '0;
      r_hold <= '0;
    end else if (w_mag > r_peak) begin
      r_peak <= w_mag;
      r_hold <= '0;
    end else if (&r_hold) begin
      r_peak <= w_peak_dec;
      r_hold <= '0;
    end else begin
      r_hold <= r_hold + PEAK_HOLD_BITS'(1);
    end
  end

  assign peak_A = r_peak;

  logic w_unused;
  assign w_unused = ^{cfg_A[31:8], cfg_A[3], w_acc_shr[AW-1:N], w_abs[N-1]};
`else
  assign peak_A = '0;

  logic w_unused;
  assign w_unused = ^{cfg_A[31:8], cfg_A[3], w_acc_shr[AW-1:N], peak_clr_A};
`endif

endmodule

// File: tb/tb_adc_frontend.sv
module tb_adc_frontend;

  logic        adc_clk;
  logic        rst;
  logic [13:0] adc_in;
  logic        adc_ovr_in;
  logic        cfg_strobe_A;
  logic [31:0] cfg_A;
  logic        peak_clr_A;
  logic [13:0] adc_data;
  logic        adc_ovfl;
  logic [13:0] dc_est_A;
  logic [12:0] peak_A;

  int n_vec = 0;
  int n_err = 0;

  adc_frontend #(
    .ADC_BITS      (14),
    .DC_ACC_GUARD  (16),
    .PEAK_HOLD_BITS(4)
  ) dut (
    .adc_clk     (adc_clk),
    .rst         (rst),
    .adc_in      (adc_in),
    .adc_ovr_in  (adc_ovr_in),
    .cfg_strobe_A(cfg_strobe_A),
    .cfg_A       (cfg_A),
    .peak_clr_A  (peak_clr_A),
    .adc_data    (adc_data),
    .adc_ovfl    (adc_ovfl),
    .dc_est_A    (dc_est_A),
    .peak_A      (peak_A)
  );

  initial begin
    adc_clk = 1'b0;
    forever #5 adc_clk = ~adc_clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic set_in(input int v);
    adc_in = v[13:0];
  endtask

  function automatic logic [31:0] cfg_word(input bit en, input bit inv, input bit clr, input int k);
    return {24'd0, 4'(k), 1'b0, clr, inv, en};
  endfunction

  task automatic load_cfg(input logic [31:0] w);
    cfg_A        = w;
    cfg_strobe_A = 1'b1;
    tick();
    cfg_strobe_A = 1'b0;
  endtask

  function automatic int sdata();
    return int'($signed(adc_data));
  endfunction

  function automatic int sest();
    return int'($signed(dc_est_A));
  endfunction

  initial begin
    rst          = 1'b1;
    adc_in       = '0;
    adc_ovr_in   = 1'b0;
    cfg_strobe_A = 1'b0;
    cfg_A        = '0;
    peak_clr_A   = 1'b0;
    tick();
    tick();

    // reset state
    check("rst_data", sdata(), 0);
    check("rst_ovfl", int'(adc_ovfl), 0);
    check("rst_est", sest(), 0);
    check("rst_peak", int'(peak_A), 0);

    // passthrough with 2-cycle latency
    rst = 1'b0;
    set_in(100);
    tick();
    check("lat_1cyc", sdata(), 0);
    tick();
    check("pass_100", sdata(), 100);
    check("pass_ovfl", int'(adc_ovfl), 0);
    check("pass_est", sest(), 0);

    // DC convergence with k=8 on a constant 1000
    set_in(1000);
    tick();
    tick();
    check("pass_1000", sdata(), 1000);
    load_cfg(cfg_word(1, 0, 0, 8));
    repeat (4096) tick();
    check("conv_est", sest(), 1000);
    check("conv_data", sdata(), 0);
    check("conv_ovfl", int'(adc_ovfl), 0);

    // dc_clr: estimate drops at once, then integrator restarts
    load_cfg(cfg_word(1, 0, 1, 8));
    check("clr_est", sest(), 0);
    tick();
    check("clr_data", sdata(), 1000);
    tick();
    check("clr_data2", sdata(), 997);
    check("clr_est2", sest(), 7);

    // reset mid-run beats a simultaneous config strobe
    rst          = 1'b1;
    cfg_A        = cfg_word(1, 1, 0, 8);
    cfg_strobe_A = 1'b1;
    tick();
    cfg_strobe_A = 1'b0;
    check("mrst_data", sdata(), 0);
    check("mrst_ovfl", int'(adc_ovfl), 0);
    check("mrst_est", sest(), 0);
    rst = 1'b0;
    tick();
    tick();
    check("mrst_track", sdata(), 1000);
    repeat (50) tick();
    check("mrst_track2", sdata(), 1000);
    check("mrst_est2", sest(), 0);

    // inversion, including full-scale negative
    set_in(0);
    load_cfg(cfg_word(0, 1, 0, 12));
    tick();
    set_in(-8192);
    tick();
    set_in(-5);
    tick();
    check("inv_min_data", sdata(), 8191);
    check("inv_min_ovfl", int'(adc_ovfl), 1);
    tick();
    check("inv_m5_data", sdata(), 5);
    check("inv_m5_ovfl", int'(adc_ovfl), 0);
    set_in(7);
    tick();
    tick();
    check("inv_p7_data", sdata(), -7);

    // overrange pin pulse
    set_in(0);
    load_cfg(cfg_word(0, 0, 0, 12));
    tick();
    adc_ovr_in = 1'b1;
    tick();
    adc_ovr_in = 1'b0;
    tick();
    check("ovr_hi", int'(adc_ovfl), 1);
    check("ovr_data", sdata(), 0);
    tick();
    check("ovr_lo", int'(adc_ovfl), 0);

    // k field 2 clamps to 4; DC of -200, then positive saturation
    set_in(-200);
    tick();
    tick();
    load_cfg(cfg_word(1, 0, 0, 2));
    check("k_est0", sest(), 0);
    tick();
    check("k_clamp_est", sest(), -13);
    repeat (400) tick();
    check("neg_est", sest(), -200);
    check("neg_data", sdata(), 0);
    set_in(8100);
    tick();
    tick();
    check("sat_data", sdata(), 8191);
    check("sat_ovfl", int'(adc_ovfl), 1);

    // peak detector
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_in(5000);
    tick();
    set_in(0);
    tick();
    tick();
`ifdef ADC_FE_PEAK_EN
    check("pk_set", int'(peak_A), 5000);
    repeat (15) tick();
    check("pk_hold", int'(peak_A), 5000);
    tick();
    check("pk_dec1", int'(peak_A), 4688);
    repeat (15) tick();
    check("pk_hold2", int'(peak_A), 4688);
    tick();
    check("pk_dec2", int'(peak_A), 4395);
    peak_clr_A = 1'b1;
    tick();
    peak_clr_A = 1'b0;
    check("pk_clr", int'(peak_A), 0);
    set_in(3000);
    tick();
    tick();
    peak_clr_A = 1'b1;
    tick();
    peak_clr_A = 1'b0;
    check("pk_clr_wins", int'(peak_A), 0);
    tick();
    check("pk_after_clr", int'(peak_A), 3000);
`else
    check("pk_off", int'(peak_A), 0);
    peak_clr_A = 1'b1;
    tick();
    peak_clr_A = 1'b0;
    set_in(3000);
    repeat (3) tick();
    check("pk_off2", int'(peak_A), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
